alu2bit_top_core: RTL and testbench

ALU2BIT_TOP_CORE -- requirements
Module: alu2bit_top

---
 rtl/alu2bit_top_core.sv | 94 +++++++++
 tb/tb_alu2bit_top_core.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu2bit_top_core.sv
// alu2bit_top_core: 2-bit ALU (add, sub, and, or) driven from buttons and
// switches, with a registered result on LEDS.
// Optional input synchronizers are enabled by defining ALU2BIT_INPUT_SYNC_EN;
// SYNC_STAGES sets their depth and has no effect when the macro is undefined.
// The design has no FSM and no handshake: it is a pure datapath with one
// result register, updated every CLK rising edge.
module alu2bit_top_core #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] BUTTONS,
   input  logic [1:0] SWITCHES,
   output logic [1:0] LEDS
);

   // Operand/select values as seen by the ALU (synchronized or direct).
   logic [3:0] btn_alu;
   logic [1:0] sw_alu;

`ifdef ALU2BIT_INPUT_SYNC_EN
   logic [3:0] btn_sync_d [SYNC_STAGES];
   logic [3:0] btn_sync_q [SYNC_STAGES];
   logic [1:0] sw_sync_d  [SYNC_STAGES];
   logic [1:0] sw_sync_q  [SYNC_STAGES];

   // Next value of each synchronizer stage: stage 0 samples the pins,
   // later stages shift the previous stage along.
   always_comb begin
      btn_sync_d[0] = BUTTONS;
      sw_sync_d[0]  = SWITCHES;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         btn_sync_d[i] = btn_sync_q[i-1];
         sw_sync_d[i]  = sw_sync_q[i-1];
      end
   end

   // Synchronizer flops; every stage clears on reset so no stale operand
   // survives it.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
         if (RESET) begin
            btn_sync_q[i] <= '0;
            sw_sync_q[i]  <= '0;
         end else begin
            btn_sync_q[i] <= btn_sync_d[i];
            sw_sync_q[i]  <= sw_sync_d[i];
         end
      end
   end

   assign btn_alu = btn_sync_q[SYNC_STAGES-1];
   assign sw_alu  = sw_sync_q[SYNC_STAGES-1];
`else
   // Depth parameter is intentionally unused without synchronizers.
   logic [31:0] unused_sync_stages;
   assign unused_sync_stages = 32'(SYNC_STAGES);

   assign btn_alu = BUTTONS;
   assign sw_alu  = SWITCHES;
`endif

   logic [1:0] leds_d;
   logic [1:0] leds_q;
   logic [1:0] op_a;
   logic [1:0] op_b;

   assign op_a = btn_alu[3:2];
   assign op_b = btn_alu[1:0];

   // ALU: 2-bit add/sub wrap modulo 4 (carry/borrow dropped), bitwise and/or.
   always_comb begin
      leds_d = 2'b00;
      case (sw_alu)
         2'b00:   leds_d = op_a + op_b;
         2'b01:   leds_d = op_a - op_b;
         2'b10:   leds_d = op_a & op_b;
         2'b11:   leds_d = op_a | op_b;
         default: leds_d = 2'b00;
      endcase
   end

   // Result register: the only driver of LEDS, so LEDS moves only on edges.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         leds_q <= 2'b00;
      end else begin
         leds_q <= leds_d;
      end
   end

   assign LEDS = leds_q;

endmodule

// File: tb/tb_alu2bit_top_core.sv
// Testbench for alu2bit_top_core: directed cases, exhaustive 64-combination
// sweep, and random stimulus against a behavioural model with a latency queue.
module tb_alu2bit_top_core;

`ifdef ALU2BIT_INPUT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] buttons;
   logic [1:0] switches;
   logic [1:0] leds;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard: model results, one per edge, oldest first.
   logic [1:0] exp_q[$];
   int         rst_hold = 0;
   logic [1:0] cur_exp;

   // Clock / reset block
   always #5 clk = ~clk;

   alu2bit_top_core dut (
      .CLK      (clk),
      .RESET    (rst),
      .BUTTONS  (buttons),
      .SWITCHES (switches),
      .LEDS     (leds)
   );

   // Reference ALU from the operation table using plain integer arithmetic.
   function automatic logic [1:0] ref_alu(input logic [3:0] b, input logic [1:0] s);
      int a_v;
      int b_v;
      int r;
      a_v = int'(b[3:2]);
      b_v = int'(b[1:0]);
      case (s)
         2'd0:    r = (a_v + b_v) % 4;
         2'd1:    r = (a_v - b_v + 4) % 4;
         2'd2:    r = a_v & b_v;
         default: r = a_v | b_v;
      endcase
      return 2'(r);
   endfunction

   task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Driver: apply inputs (called at a negedge), clock one edge, update the
   // model, then check LEDS at the following negedge.
   task automatic drive_cycle(input logic r, input logic [3:0] b, input logic [1:0] s,
                              input string tag);
      rst      = r;
      buttons  = b;
      switches = s;
      @(posedge clk);
      exp_q.push_back(ref_alu(b, s));
      while (exp_q.size() > LAT) void'(exp_q.pop_front());
      if (r) rst_hold = LAT;
      if (rst_hold > 0) begin
         cur_exp = 2'b00;
         rst_hold--;
      end else begin
         cur_exp = exp_q[0];
      end
      @(negedge clk);
      check(tag, leds, cur_exp);
   endtask

   // Hold an operation for the full latency, then compare against a constant.
   task automatic hold_op(input logic [3:0] b, input logic [1:0] s, input string tag,
                          input logic [1:0] want);
      repeat (LAT) drive_cycle(1'b0, b, s, tag);
      check({tag, "_const"}, leds, want);
   endtask

   initial begin
      logic [3:0] rb;
      logic [1:0] rs;
      logic       rr;

      rst      = 1'b1;
      buttons  = 4'hF;
      switches = 2'b00;
      @(negedge clk);

      // Reset with all operands high: LEDS must read 00 throughout.
      drive_cycle(1'b1, 4'hF, 2'b00, "reset0");
      check("reset0_const", leds, 2'b00);
      drive_cycle(1'b1, 4'hF, 2'b00, "reset1");
      check("reset1_const", leds, 2'b00);

      // Directed operations.
      hold_op(4'd13, 2'b10, "and_3_1",  2'b01);
      hold_op(4'd3,  2'b00, "add_0_3",  2'b11);
      hold_op(4'd15, 2'b00, "add_wrap", 2'b10);
      hold_op(4'd7,  2'b11, "or_1_3",   2'b11);
      hold_op(4'd6,  2'b01, "sub_1_2",  2'b11);
      hold_op(4'd9,  2'b01, "sub_2_1",  2'b01);
      hold_op(4'd1,  2'b01, "sub_0_1",  2'b11);

      // Reset pulse between edges must not disturb LEDS.
      #2 rst = 1'b1;
      #1 check("async_rst_glitch", leds, 2'b11);
      rst = 1'b0;
      #1 check("async_rst_after", leds, 2'b11);
      @(negedge clk);
      check("async_rst_edge", leds, 2'b11);

      // Reset mid-stream overrides in-flight results, then recovery.
      drive_cycle(1'b1, 4'd15, 2'b11, "rst_mid");
      for (int i = 0; i < LAT + 1; i++) drive_cycle(1'b0, 4'd15, 2'b11, "rst_recover");
      check("rst_recover_const", leds, 2'b11);

      // Exhaustive sweep: every operand pair with every operation.
      for (int i = 0; i < 64; i++) begin
         drive_cycle(1'b0, 4'(i >> 2), 2'(i), "sweep");
      end
      for (int i = 0; i < LAT; i++) drive_cycle(1'b0, 4'd0, 2'b00, "sweep_drain");

      // Random stimulus with occasional holds and resets.
      rb = 4'd0;
      rs = 2'd0;
      for (int i = 0; i < 400; i++) begin
         rr = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 3) != 0) begin
            rb = 4'($urandom_range(0, 15));
            rs = 2'($urandom_range(0, 3));
         end
         drive_cycle(rr, rb, rs, "random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
